// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for miniLA: operand forwarding from EX/MEM/WB,
// load-use bubble insertion, hold/flush handling and a load-use bubble counter.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [4:0]       id_rR1,
  input  logic [4:0]       id_rR2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [4:0]       id_wR,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic [31:0]      id_imm,
  input  logic [15:0]      id_ctrl,
  input  logic [31:0]      rf_rD1,
  input  logic [31:0]      rf_rD2,
  input  logic [31:0]      ex_result,
  input  logic             mem_we,
  input  logic [4:0]       mem_wR,
  input  logic [31:0]      mem_wD,
  input  logic             wb_we,
  input  logic [4:0]       wb_wR,
  input  logic [31:0]      wb_wD,
  input  logic             ex_hold,
  input  logic             flush,
  output logic             stall_id,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_src1,
  output logic [31:0]      ex_src2,
  output logic [31:0]      ex_imm,
  output logic [15:0]      ex_ctrl,
  output logic [4:0]       ex_wR,
  output logic             ex_we,
  output logic             ex_is_load,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             valid_reg, valid_next;
  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      src1_reg, src1_next;
  logic [31:0]      src2_reg, src2_next;
  logic [31:0]      imm_reg, imm_next;
  logic [15:0]      ctrl_reg, ctrl_next;
  logic [4:0]       wr_reg, wr_next;
  logic             we_reg, we_next;
  logic             is_load_reg, is_load_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [1:0][4:0]  src_idx;
  logic [1:0]       src_use;
  logic [1:0][31:0] rf_val;
  logic             lu;

  assign src_idx = {id_rR2, id_rR1};
  assign src_use = {id_use2, id_use1};
  assign rf_val  = {rf_rD2, rf_rD1};

  // Per-source bypass mux; a load in EX has no data yet, so it never forwards from EX.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [31:0] val;
      logic        lu_src;

      assign lu_src = src_use[gi] && (src_idx[gi] == wr_reg);

      always_comb begin
        val = rf_val[gi];
        if (src_use[gi] && (src_idx[gi] != 5'd0)) begin
          if (valid_reg && we_reg && !is_load_reg && (wr_reg == src_idx[gi]))
            val = ex_result;
          else if (mem_we && (mem_wR == src_idx[gi]))
            val = mem_wD;
          else if (wb_we && (wb_wR == src_idx[gi]))
            val = wb_wD;
        end
      end
    end
  endgenerate

  assign lu = id_valid && valid_reg && is_load_reg && (wr_reg != 5'd0)
              && (g_fwd[0].lu_src || g_fwd[1].lu_src);

  assign stall_id = !flush && (ex_hold || lu);

  always_comb begin
    valid_next   = valid_reg;
    pc_next      = pc_reg;
    src1_next    = src1_reg;
    src2_next    = src2_reg;
    imm_next     = imm_reg;
    ctrl_next    = ctrl_reg;
    wr_next      = wr_reg;
    we_next      = we_reg;
    is_load_next = is_load_reg;
    cnt_next     = cnt_reg;
    if (flush || (!ex_hold && lu)) begin
      valid_next   = 1'b0;
      pc_next      = 32'd0;
      src1_next    = 32'd0;
      src2_next    = 32'd0;
      imm_next     = 32'd0;
      ctrl_next    = 16'd0;
      wr_next      = 5'd0;
      we_next      = 1'b0;
      is_load_next = 1'b0;
      // Only a bubble that actually wins (no flush, no hold) is counted.
      if (!flush && (cnt_reg != {CNT_W{1'b1}}))
        cnt_next = cnt_reg + CNT_W'(1);
    end else if (!ex_hold) begin
      valid_next   = id_valid;
      pc_next      = id_pc;
      src1_next    = g_fwd[0].val;
      src2_next    = g_fwd[1].val;
      imm_next     = id_imm;
      ctrl_next    = id_ctrl;
      wr_next      = id_wR;
      we_next      = id_we && id_valid;
      is_load_next = id_is_load && id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg   <= 1'b0;
      pc_reg      <= 32'd0;
      src1_reg    <= 32'd0;
      src2_reg    <= 32'd0;
      imm_reg     <= 32'd0;
      ctrl_reg    <= 16'd0;
      wr_reg      <= 5'd0;
      we_reg      <= 1'b0;
      is_load_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      valid_reg   <= valid_next;
      pc_reg      <= pc_next;
      src1_reg    <= src1_next;
      src2_reg    <= src2_next;
      imm_reg     <= imm_next;
      ctrl_reg    <= ctrl_next;
      wr_reg      <= wr_next;
      we_reg      <= we_next;
      is_load_reg <= is_load_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign ex_valid   = valid_reg;
  assign ex_pc      = pc_reg;
  assign ex_src1    = src1_reg;
  assign ex_src2    = src2_reg;
  assign ex_imm     = imm_reg;
  assign ex_ctrl    = ctrl_reg;
  assign ex_wR      = wr_reg;
  assign ex_we      = we_reg;
  assign ex_is_load = is_load_reg;
  assign bubble_cnt = cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding, load-use, hold/flush, async reset,
// and counter saturation on a second narrow-counter instance.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use1, id_use2, id_we, id_is_load;
  logic [31:0] id_pc, id_imm, rf_rD1, rf_rD2, ex_result, mem_wD, wb_wD;
  logic [4:0]  id_rR1, id_rR2, id_wR, mem_wR, wb_wR;
  logic [15:0] id_ctrl;
  logic        mem_we, wb_we, ex_hold, flush;

  logic        stall_id, ex_valid, ex_we, ex_is_load;
  logic [31:0] ex_pc, ex_src1, ex_src2, ex_imm;
  logic [15:0] ex_ctrl;
  logic [4:0]  ex_wR;
  logic [15:0] bubble_cnt;

  logic        s_stall_id, s_ex_valid, s_ex_we, s_ex_is_load;
  logic [31:0] s_ex_pc, s_ex_src1, s_ex_src2, s_ex_imm;
  logic [15:0] s_ex_ctrl;
  logic [4:0]  s_ex_wR;
  logic [1:0]  s_bubble_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rR1(id_rR1), .id_rR2(id_rR2), .id_use1(id_use1), .id_use2(id_use2),
    .id_wR(id_wR), .id_we(id_we), .id_is_load(id_is_load), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .rf_rD1(rf_rD1), .rf_rD2(rf_rD2), .ex_result(ex_result),
    .mem_we(mem_we), .mem_wR(mem_wR), .mem_wD(mem_wD), .wb_we(wb_we),
    .wb_wR(wb_wR), .wb_wD(wb_wD), .ex_hold(ex_hold), .flush(flush),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_src1(ex_src1),
    .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_wR(ex_wR),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rR1(id_rR1), .id_rR2(id_rR2), .id_use1(id_use1), .id_use2(id_use2),
    .id_wR(id_wR), .id_we(id_we), .id_is_load(id_is_load), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .rf_rD1(rf_rD1), .rf_rD2(rf_rD2), .ex_result(ex_result),
    .mem_we(mem_we), .mem_wR(mem_wR), .mem_wD(mem_wD), .wb_we(wb_we),
    .wb_wR(wb_wR), .wb_wD(wb_wD), .ex_hold(ex_hold), .flush(flush),
    .stall_id(s_stall_id), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_src1(s_ex_src1),
    .ex_src2(s_ex_src2), .ex_imm(s_ex_imm), .ex_ctrl(s_ex_ctrl), .ex_wR(s_ex_wR),
    .ex_we(s_ex_we), .ex_is_load(s_ex_is_load), .bubble_cnt(s_bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_pc = 0; id_rR1 = 0; id_rR2 = 0; id_use1 = 0; id_use2 = 0;
    id_wR = 0; id_we = 0; id_is_load = 0; id_imm = 0; id_ctrl = 0;
    rf_rD1 = 0; rf_rD2 = 0; ex_result = 0; mem_we = 0; mem_wR = 0; mem_wD = 0;
    wb_we = 0; wb_wR = 0; wb_wD = 0; ex_hold = 0; flush = 0;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic [4:0] wr,
                        input logic we, input logic ld);
    id_valid = 1; id_pc = pc; id_rR1 = r1; id_use1 = u1; id_rR2 = r2; id_use2 = u2;
    id_wR = wr; id_we = we; id_is_load = ld;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #2;
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_pc", ex_pc, 32'd0);
    chk("reset_cnt", {16'd0, bubble_cnt}, 32'd0);
    tick();
    rst_n = 1;

    // Back-to-back ALU RAW
    set_id(32'h100, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    tick();
    chk("raw_first_we", {31'd0, ex_we}, 32'd1);
    chk("raw_first_wR", {27'd0, ex_wR}, 32'd5);
    set_id(32'h104, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
    rf_rD1 = 32'h99; rf_rD2 = 32'h98; ex_result = 32'h11;
    #1;
    chk("raw_stall", {31'd0, stall_id}, 32'd0);
    tick();
    chk("raw_src1", ex_src1, 32'h11);
    chk("raw_src2", ex_src2, 32'h11);
    chk("raw_pc", ex_pc, 32'h104);

    // EX > MEM > WB priority on r7
    idle();
    set_id(32'h108, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0);
    tick();
    set_id(32'h10c, 5'd7, 1, 5'd7, 1, 5'd0, 1, 0);
    rf_rD1 = 32'h77; rf_rD2 = 32'h77; ex_result = 32'hA;
    mem_we = 1; mem_wR = 5'd7; mem_wD = 32'hB;
    wb_we = 1; wb_wR = 5'd7; wb_wD = 32'hC;
    tick();
    chk("prio_src1_ex", ex_src1, 32'hA);
    chk("prio_src2_ex", ex_src2, 32'hA);
    // r0 is never forwarded, even with every producer targeting r0
    set_id(32'h110, 5'd0, 1, 5'd0, 1, 5'd9, 0, 0);
    rf_rD1 = 0; rf_rD2 = 0; mem_wR = 5'd0; wb_wR = 5'd0;
    tick();
    chk("r0_src1", ex_src1, 32'd0);
    chk("r0_src2", ex_src2, 32'd0);
    // MEM beats WB; unused source takes RF value
    set_id(32'h114, 5'd7, 1, 5'd7, 0, 5'd9, 0, 0);
    rf_rD1 = 32'h77; rf_rD2 = 32'h22; mem_wR = 5'd7; wb_wR = 5'd7;
    tick();
    chk("prio_src1_mem", ex_src1, 32'hB);
    chk("unused_src2_rf", ex_src2, 32'h22);

    // WB same-cycle bypass
    idle();
    set_id(32'h118, 5'd1, 1, 5'd3, 1, 5'd9, 0, 0);
    rf_rD1 = 32'h1234; rf_rD2 = 32'h1;
    wb_we = 1; wb_wR = 5'd3; wb_wD = 32'hDEAD;
    tick();
    chk("wb_src2", ex_src2, 32'hDEAD);
    chk("wb_src1_rf", ex_src1, 32'h1234);

    // Load-use
    idle();
    set_id(32'h1fc, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
    tick();
    chk("lu_load_flag", {31'd0, ex_is_load}, 32'd1);
    set_id(32'h200, 5'd4, 1, 5'd0, 0, 5'd10, 1, 0);
    rf_rD1 = 32'h3;
    #1;
    chk("lu_stall", {31'd0, stall_id}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_we", {31'd0, ex_we}, 32'd0);
    chk("lu_cnt", {16'd0, bubble_cnt}, 32'd1);
    chk("lu_stall_gone", {31'd0, stall_id}, 32'd0);
    mem_we = 1; mem_wR = 5'd4; mem_wD = 32'h55;
    tick();
    chk("lu_retry_src1", ex_src1, 32'h55);
    chk("lu_retry_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_retry_pc", ex_pc, 32'h200);

    // Flush beats hold
    idle();
    set_id(32'h204, 5'd0, 0, 5'd0, 0, 5'd11, 1, 0);
    flush = 1; ex_hold = 1;
    #1;
    chk("flush_hold_stall", {31'd0, stall_id}, 32'd0);
    tick();
    chk("flush_hold_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_hold_we", {31'd0, ex_we}, 32'd0);

    // Flush beats lu, counter untouched
    idle();
    set_id(32'h208, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
    tick();
    set_id(32'h20c, 5'd0, 0, 5'd4, 1, 5'd12, 1, 0);
    flush = 1;
    #1;
    chk("flush_lu_stall", {31'd0, stall_id}, 32'd0);
    tick();
    chk("flush_lu_cnt", {16'd0, bubble_cnt}, 32'd1);
    chk("flush_lu_valid", {31'd0, ex_valid}, 32'd0);

    // Hold for 3 cycles
    idle();
    set_id(32'h300, 5'd1, 0, 5'd2, 0, 5'd12, 1, 0);
    id_imm = 32'h1111; id_ctrl = 16'hABCD; rf_rD1 = 32'h5A; rf_rD2 = 32'h5B;
    tick();
    set_id(32'h400, 5'd1, 0, 5'd2, 0, 5'd13, 1, 0);
    id_imm = 32'h2222; id_ctrl = 16'h1234; rf_rD1 = 32'h6A; rf_rD2 = 32'h6B;
    ex_hold = 1;
    #1;
    chk("hold_stall", {31'd0, stall_id}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold%0d_pc", i), ex_pc, 32'h300);
      chk($sformatf("hold%0d_src1", i), ex_src1, 32'h5A);
      chk($sformatf("hold%0d_imm", i), ex_imm, 32'h1111);
      chk($sformatf("hold%0d_ctrl", i), {16'd0, ex_ctrl}, 32'hABCD);
    end
    ex_hold = 0;
    tick();
    chk("hold_release_pc", ex_pc, 32'h400);
    chk("hold_release_src2", ex_src2, 32'h6B);

    // Async reset between edges
    #2;
    rst_n = 0;
    #1;
    chk("areset_valid", {31'd0, ex_valid}, 32'd0);
    chk("areset_we", {31'd0, ex_we}, 32'd0);
    chk("areset_cnt", {16'd0, bubble_cnt}, 32'd0);
    #2;
    rst_n = 1;
    idle();
    tick();

    // Five lu events: wide counter reaches 5, 2-bit counter sticks at 3
    for (int i = 0; i < 5; i++) begin
      idle();
      set_id(32'h500, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
      tick();
      set_id(32'h504, 5'd4, 1, 5'd0, 0, 5'd14, 1, 0);
      tick();
    end
    chk("sat_wide_cnt", {16'd0, bubble_cnt}, 32'd5);
    chk("sat_small_cnt", {30'd0, s_bubble_cnt}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
